// File: rtl/axi_rw_arbiter_if.sv
// Bus bundle for the two-master / one-slave AXI-style read/write arbiter.
//
// Handshake rule for every channel in this bundle: a beat transfers on a
// rising clk edge where both valid and ready are high. The sender holds
// valid and its payload stable until that edge; ready may rise or fall
// freely and never depends on anything but the receiver's own state and
// inputs.
//
// Master-side signals (m_*) are packed two-wide, master i in slice i.
// Address words are {ADDR, LEN[3:0], ID[3:0]}.
//
// Modports:
//   slave  - the arbiter's view: takes master requests, drives the slave bus
//   master - the surrounding environment's view (the opposite directions)
interface axi_rw_arbiter_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int BRESP_W = 5
);
    localparam int AX_W = ADDR_W + 8;

    // read address / read data, master side
    logic [1:0]          m_arvalid;
    logic [1:0]          m_arready;
    logic [2*AX_W-1:0]   m_ar;
    logic [1:0]          m_rvalid;
    logic [1:0]          m_rready;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_rresp;
    logic                m_rlast;
    // read address / read data, slave side
    logic                s_arvalid;
    logic                s_arready;
    logic [AX_W-1:0]     s_ar;
    logic                s_rvalid;
    logic                s_rready;
    logic [DATA_W-1:0]   s_rdata;
    logic                s_rresp;
    logic                s_rlast;
    // write address / data / response, master side
    logic [1:0]          m_awvalid;
    logic [1:0]          m_awready;
    logic [2*AX_W-1:0]   m_aw;
    logic [1:0]          m_wvalid;
    logic [1:0]          m_wready;
    logic [2*DATA_W-1:0] m_wdata;
    logic [1:0]          m_wlast;
    logic [1:0]          m_bvalid;
    logic [1:0]          m_bready;
    logic [BRESP_W-1:0]  m_bresp;
    // write address / data / response, slave side
    logic                s_awvalid;
    logic                s_awready;
    logic [AX_W-1:0]     s_aw;
    logic                s_wvalid;
    logic                s_wready;
    logic [DATA_W-1:0]   s_wdata;
    logic                s_wlast;
    logic                s_bvalid;
    logic                s_bready;
    logic [BRESP_W-1:0]  s_bresp;

    modport slave (
        input  m_arvalid, m_ar, m_rready, m_awvalid, m_aw, m_wvalid, m_wdata,
               m_wlast, m_bready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_awready,
               m_wready, m_bvalid, m_bresp,
        output s_arvalid, s_ar, s_rready, s_awvalid, s_aw, s_wvalid, s_wdata,
               s_wlast, s_bready,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_awready,
               s_wready, s_bvalid, s_bresp
    );

    modport master (
        output m_arvalid, m_ar, m_rready, m_awvalid, m_aw, m_wvalid, m_wdata,
               m_wlast, m_bready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_awready,
               m_wready, m_bvalid, m_bresp,
        input  s_arvalid, s_ar, s_rready, s_awvalid, s_aw, s_wvalid, s_wdata,
               s_wlast, s_bready,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_awready,
               s_wready, s_bvalid, s_bresp
    );
endinterface

// File: rtl/axi_rw_arbiter.sv
// Two-master, one-slave arbiter for the AXI-style read and write channels.
// Reads (AR/R) and writes (AW/W/B) are arbitrated independently, each with
// its own round-robin pointer; a grant is held until RLAST (reads) or the
// B handshake (writes). The slave-side WLAST is generated from a beat
// counter against the latched AW length, and a sticky per-master flag
// records any accepted beat whose master WLAST disagreed with it.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           axi_rw_arbiter_if.slave, all channel signals
//   wlast_err     sticky per-master WLAST/length mismatch
//   rd_gnt        one-hot read grant, 0 when idle
//   wr_gnt        one-hot write grant, 0 when idle
//   rd_state_dbg  read FSM state (0 idle, 1 addr, 2 data)
//   wr_state_dbg  write FSM state (0 idle, 1 addr, 2 data, 3 resp)
//
// Only state, grants, pointers, length/counter and wlast_err are registered;
// every channel output is a mux steered by the registered grant and state,
// so the non-granted master always sees 0 on its ready/valid.
module axi_rw_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    axi_rw_arbiter_if.slave     bus,
    output logic [1:0]          wlast_err,
    output logic [1:0]          rd_gnt,
    output logic [1:0]          wr_gnt,
    output logic [1:0]          rd_state_dbg,
    output logic [1:0]          wr_state_dbg
);
    localparam int AX_W = ADDR_W + 8;

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

    rd_state_t rd_state;
    wr_state_t wr_state;
    logic      rd_last;     // index of the last master granted a read
    logic      wr_last;     // index of the last master granted a write
    logic [3:0] wr_len;
    logic [4:0] wr_cnt;

    // Grant index; only meaningful while the matching state is not idle.
    logic rd_sel, wr_sel;
    assign rd_sel = rd_gnt[1];
    assign wr_sel = wr_gnt[1];

    logic [AX_W-1:0] ar_sel, aw_sel;
    assign ar_sel = rd_sel ? bus.m_ar[2*AX_W-1:AX_W] : bus.m_ar[AX_W-1:0];
    assign aw_sel = wr_sel ? bus.m_aw[2*AX_W-1:AX_W] : bus.m_aw[AX_W-1:0];

    logic w_beat, w_is_last;
    assign w_is_last = (wr_cnt == {1'b0, wr_len});
    assign w_beat    = (wr_state == WR_DATA) && bus.m_wvalid[wr_sel] && bus.s_wready;

    assign rd_state_dbg = rd_state;
    assign wr_state_dbg = wr_state;

    // Round robin: a lone requester wins outright; on a tie the master
    // that was not granted last time wins.
    function automatic logic [1:0] pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) pick = last ? 2'b01 : 2'b10;
        else              pick = req;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_gnt   <= 2'b00;
            rd_last  <= 1'b1;
        end else begin
            case (rd_state)
                RD_IDLE: if (|bus.m_arvalid) begin
                    rd_gnt   <= pick(bus.m_arvalid, rd_last);
                    rd_state <= RD_ADDR;
                end
                RD_ADDR: if (bus.s_arready) rd_state <= RD_DATA;
                RD_DATA: if (bus.s_rvalid && bus.m_rready[rd_sel] && bus.s_rlast) begin
                    rd_last  <= rd_sel;
                    rd_gnt   <= 2'b00;
                    rd_state <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state  <= WR_IDLE;
            wr_gnt    <= 2'b00;
            wr_last   <= 1'b1;
            wr_len    <= 4'd0;
            wr_cnt    <= 5'd0;
            wlast_err <= 2'b00;
        end else begin
            case (wr_state)
                WR_IDLE: if (|bus.m_awvalid) begin
                    wr_gnt   <= pick(bus.m_awvalid, wr_last);
                    wr_state <= WR_ADDR;
                end
                WR_ADDR: if (bus.s_awready) begin
                    wr_len   <= aw_sel[7:4];
                    wr_cnt   <= 5'd0;
                    wr_state <= WR_DATA;
                end
                WR_DATA: if (w_beat) begin
                    wr_cnt <= wr_cnt + 5'd1;
                    // The burst length decides completion; a wrong master
                    // WLAST is only recorded.
                    if (bus.m_wlast[wr_sel] != w_is_last) wlast_err[wr_sel] <= 1'b1;
                    if (w_is_last) wr_state <= WR_RESP;
                end
                WR_RESP: if (bus.s_bvalid && bus.m_bready[wr_sel]) begin
                    wr_last  <= wr_sel;
                    wr_gnt   <= 2'b00;
                    wr_state <= WR_IDLE;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.s_arvalid = 1'b0;
        bus.s_ar      = '0;
        bus.m_arready = 2'b00;
        bus.m_rvalid  = 2'b00;
        bus.s_rready  = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = 1'b0;
        bus.m_rlast   = 1'b0;
        if (rd_state == RD_ADDR) begin
            bus.s_arvalid         = 1'b1;
            bus.s_ar              = ar_sel;
            bus.m_arready[rd_sel] = bus.s_arready;
        end
        if (rd_state == RD_DATA) begin
            bus.m_rvalid[rd_sel] = bus.s_rvalid;
            bus.s_rready         = bus.m_rready[rd_sel];
            bus.m_rdata          = bus.s_rdata;
            bus.m_rresp          = bus.s_rresp;
            bus.m_rlast          = bus.s_rlast;
        end
    end

    always_comb begin
        bus.s_awvalid = 1'b0;
        bus.s_aw      = '0;
        bus.m_awready = 2'b00;
        bus.s_wvalid  = 1'b0;
        bus.s_wdata   = '0;
        bus.s_wlast   = 1'b0;
        bus.m_wready  = 2'b00;
        bus.m_bvalid  = 2'b00;
        bus.s_bready  = 1'b0;
        bus.m_bresp   = '0;
        if (wr_state == WR_ADDR) begin
            bus.s_awvalid         = 1'b1;
            bus.s_aw              = aw_sel;
            bus.m_awready[wr_sel] = bus.s_awready;
        end
        if (wr_state == WR_DATA) begin
            bus.s_wvalid         = bus.m_wvalid[wr_sel];
            bus.s_wdata          = wr_sel ? bus.m_wdata[15:8] : bus.m_wdata[7:0];
            bus.s_wlast          = w_is_last;
            bus.m_wready[wr_sel] = bus.s_wready;
        end
        if (wr_state == WR_RESP) begin
            bus.m_bvalid[wr_sel] = bus.s_bvalid;
            bus.s_bready         = bus.m_bready[wr_sel];
            bus.m_bresp          = bus.s_bresp;
        end
    end
endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Bench for axi_rw_arbiter: directed transactions, a transaction-level
// model checked against every output on every falling edge, data
// scoreboards and literal checkpoints from the test plan.
module tb_axi_rw_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_rw_arbiter_if bus();
    logic [1:0] wlast_err, rd_gnt, wr_gnt, rd_state_dbg, wr_state_dbg;

    axi_rw_arbiter dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .wlast_err(wlast_err), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rd_exp_q[$];
    logic [7:0] wr_exp_q[$];

    // observation trackers
    int rd_beats[2] = '{0, 0};
    int sw_beat = 0, wlast_at = 0, wlast_cnt = 0, b_cnt = 0;
    logic [4:0] last_bresp = 5'h1f;
    bit both_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    int md_rd_own = -1, md_rd_ptr = 1, md_wr_own = -1, md_wr_ptr = 1;
    bit md_rd_addr_done = 0;
    int md_wr_phase = 0;   // 0 address, 1 data, 2 response
    int md_wr_beats = 0, md_wr_len = 0;
    logic [1:0] md_err = 2'b00;

    function automatic int pick_master(input logic [1:0] req, input int last);
        if (req == 2'b11) return 1 - last;
        return req[1] ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit last_b;
        if (rst) begin
            md_rd_own = -1; md_rd_ptr = 1; md_rd_addr_done = 0;
            md_wr_own = -1; md_wr_ptr = 1; md_wr_phase = 0;
            md_wr_beats = 0; md_wr_len = 0; md_err = 2'b00;
        end else begin
            if (md_rd_own < 0) begin
                if (bus.m_arvalid != 2'b00) begin
                    md_rd_own = pick_master(bus.m_arvalid, md_rd_ptr);
                    md_rd_addr_done = 0;
                end
            end else if (!md_rd_addr_done) begin
                if (bus.s_arready) md_rd_addr_done = 1;
            end else if (bus.s_rvalid && bus.m_rready[md_rd_own] && bus.s_rlast) begin
                md_rd_ptr = md_rd_own;
                md_rd_own = -1;
            end

            if (md_wr_own < 0) begin
                if (bus.m_awvalid != 2'b00) begin
                    md_wr_own = pick_master(bus.m_awvalid, md_wr_ptr);
                    md_wr_phase = 0;
                end
            end else if (md_wr_phase == 0) begin
                if (bus.s_awready) begin
                    md_wr_phase = 1;
                    md_wr_beats = 0;
                    md_wr_len = int'(bus.m_aw[md_wr_own*16+4 +: 4]);
                end
            end else if (md_wr_phase == 1) begin
                if (bus.m_wvalid[md_wr_own] && bus.s_wready) begin
                    last_b = (md_wr_beats == md_wr_len);
                    if (bus.m_wlast[md_wr_own] != last_b) md_err[md_wr_own] = 1'b1;
                    if (last_b) md_wr_phase = 2;
                    else md_wr_beats++;
                end
            end else begin
                if (bus.s_bvalid && bus.m_bready[md_wr_own]) begin
                    md_wr_ptr = md_wr_own;
                    md_wr_own = -1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [1:0]  e_rd_gnt, e_m_arready, e_m_rvalid, e_wr_gnt, e_m_awready, e_m_wready, e_m_bvalid;
        logic        e_s_arvalid, e_s_rready, e_m_rresp, e_m_rlast, e_s_awvalid, e_s_wvalid, e_s_wlast, e_s_bready;
        logic [15:0] e_s_ar, e_s_aw;
        logic [7:0]  e_m_rdata, e_s_wdata;
        logic [4:0]  e_m_bresp;
        e_rd_gnt = 0; e_m_arready = 0; e_m_rvalid = 0; e_s_arvalid = 0; e_s_rready = 0;
        e_m_rresp = 0; e_m_rlast = 0; e_s_ar = 0; e_m_rdata = 0;
        e_wr_gnt = 0; e_m_awready = 0; e_m_wready = 0; e_m_bvalid = 0; e_s_awvalid = 0;
        e_s_wvalid = 0; e_s_wlast = 0; e_s_bready = 0; e_s_aw = 0; e_s_wdata = 0; e_m_bresp = 0;

        if (md_rd_own >= 0) begin
            e_rd_gnt = 2'b01 << md_rd_own;
            if (!md_rd_addr_done) begin
                e_s_arvalid = 1;
                e_s_ar = bus.m_ar[md_rd_own*16 +: 16];
                if (bus.s_arready) e_m_arready = e_rd_gnt;
            end else begin
                if (bus.s_rvalid) e_m_rvalid = e_rd_gnt;
                e_s_rready = bus.m_rready[md_rd_own];
                e_m_rdata = bus.s_rdata;
                e_m_rresp = bus.s_rresp;
                e_m_rlast = bus.s_rlast;
            end
        end
        if (md_wr_own >= 0) begin
            e_wr_gnt = 2'b01 << md_wr_own;
            if (md_wr_phase == 0) begin
                e_s_awvalid = 1;
                e_s_aw = bus.m_aw[md_wr_own*16 +: 16];
                if (bus.s_awready) e_m_awready = e_wr_gnt;
            end else if (md_wr_phase == 1) begin
                e_s_wvalid = bus.m_wvalid[md_wr_own];
                e_s_wdata = bus.m_wdata[md_wr_own*8 +: 8];
                e_s_wlast = (md_wr_beats == md_wr_len);
                if (bus.s_wready) e_m_wready = e_wr_gnt;
            end else begin
                if (bus.s_bvalid) e_m_bvalid = e_wr_gnt;
                e_s_bready = bus.m_bready[md_wr_own];
                e_m_bresp = bus.s_bresp;
            end
        end

        chk("rd_addr", {rd_gnt, bus.m_arready, bus.s_arvalid, bus.s_ar},
                       {e_rd_gnt, e_m_arready, e_s_arvalid, e_s_ar});
        chk("rd_data", {bus.m_rvalid, bus.s_rready, bus.m_rdata, bus.m_rresp, bus.m_rlast},
                       {e_m_rvalid, e_s_rready, e_m_rdata, e_m_rresp, e_m_rlast});
        chk("wr_addr", {wr_gnt, bus.m_awready, bus.s_awvalid, bus.s_aw},
                       {e_wr_gnt, e_m_awready, e_s_awvalid, e_s_aw});
        chk("wr_data", {bus.m_wready, bus.s_wvalid, bus.s_wdata, bus.s_wlast},
                       {e_m_wready, e_s_wvalid, e_s_wdata, e_s_wlast});
        chk("wr_resp", {bus.m_bvalid, bus.s_bready, bus.m_bresp},
                       {e_m_bvalid, e_s_bready, e_m_bresp});
        chk("wlast_err", wlast_err, md_err);

        if (rst) begin
            sw_beat = 0;
            wr_exp_q.delete();
            rd_exp_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.m_rvalid[i] && bus.m_rready[i]) begin
                    rd_beats[i]++;
                    if (rd_exp_q.size() == 0) fail_now("rd_data_unexpected_beat");
                    else chk("rd_data_sb", bus.m_rdata, rd_exp_q.pop_front());
                end
            end
            if (bus.s_wvalid && bus.s_wready) begin
                sw_beat++;
                if (wr_exp_q.size() == 0) fail_now("wr_data_unexpected_beat");
                else chk("wr_data_sb", bus.s_wdata, wr_exp_q.pop_front());
                if (bus.s_wlast) begin
                    wlast_at = sw_beat;
                    wlast_cnt++;
                    sw_beat = 0;
                end
            end
            if ((bus.m_bvalid & bus.m_bready) != 2'b00) begin
                last_bresp = bus.m_bresp;
                b_cnt++;
            end
            if (rd_gnt == 2'b01 && wr_gnt == 2'b10) both_seen = 1;
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.m_arvalid = 0; bus.m_ar = 0; bus.m_rready = 0;
        bus.m_awvalid = 0; bus.m_aw = 0; bus.m_wvalid = 0; bus.m_wdata = 0;
        bus.m_wlast = 0; bus.m_bready = 0;
        bus.s_arready = 0; bus.s_rvalid = 0; bus.s_rdata = 0; bus.s_rresp = 0; bus.s_rlast = 0;
        bus.s_awready = 0; bus.s_wready = 0; bus.s_bvalid = 0; bus.s_bresp = 0;
    endtask

    task automatic wait_gnt(input bit is_wr, input int m, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (is_wr ? (wr_gnt == (2'b01 << m) && bus.s_awvalid)
                      : (rd_gnt == (2'b01 << m) && bus.s_arvalid)) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) $display("FAIL grant_timeout: %s master %0d not granted in 100 cycles",
                          is_wr ? "write" : "read", m);
        if (!ok) begin n_checks++; n_fail++; end
    endtask

    // Slave side of a read for master m, whose request is already raised.
    task automatic rd_txn(input int m, input logic [3:0] len, input bit gappy);
        bit ok;
        logic [7:0] d;
        wait_gnt(0, m, ok);
        if (!ok) return;
        bus.s_arready = 1;
        tick();
        bus.s_arready = 0;
        bus.m_arvalid[m] = 0;
        bus.m_rready[m] = 1;
        for (int b = 0; b <= int'(len); b++) begin
            if (gappy) begin
                bus.s_rvalid = 0;
                tick();
            end
            d = 8'hC0 + 8'(m * 16) + 8'(b);
            bus.s_rvalid = 1;
            bus.s_rdata = d;
            bus.s_rresp = d[0];
            bus.s_rlast = (b == int'(len));
            rd_exp_q.push_back(d);
            tick();
        end
        bus.s_rvalid = 0;
        bus.s_rlast = 0;
        bus.m_rready[m] = 0;
    endtask

    // Full write for master m, whose AW request is already raised.
    task automatic wr_txn(input int m, input logic [3:0] len, input logic [7:0] d0,
                          input int wlast_beat, input logic [4:0] resp);
        bit ok;
        logic [7:0] d;
        wait_gnt(1, m, ok);
        if (!ok) return;
        bus.s_awready = 1;
        tick();
        bus.s_awready = 0;
        bus.m_awvalid[m] = 0;
        bus.s_wready = 1;
        for (int b = 0; b <= int'(len); b++) begin
            d = d0 + 8'(b);
            bus.m_wvalid[m] = 1;
            bus.m_wdata[m*8 +: 8] = d;
            bus.m_wlast[m] = (b == wlast_beat);
            wr_exp_q.push_back(d);
            tick();
        end
        bus.m_wvalid[m] = 0;
        bus.m_wlast[m] = 0;
        bus.s_wready = 0;
        bus.s_bvalid = 1;
        bus.s_bresp = resp;
        bus.m_bready[m] = 1;
        tick();
        bus.s_bvalid = 0;
        bus.s_bresp = 0;
        bus.m_bready[m] = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s0, s1, sw, sb;
        bit ok;
        rst = 1;
        drive_idle();
        tick();
        tick();
        rst = 0;
        chk("reset_rd_gnt", rd_gnt, 2'b00);
        chk("reset_wr_gnt", wr_gnt, 2'b00);
        chk("reset_wlast_err", wlast_err, 2'b00);
        chk("reset_s_valids", {bus.s_arvalid, bus.s_awvalid, bus.s_wvalid}, 3'b000);

        // 1: simultaneous reads, master0 first, then master1
        bus.m_ar = {8'h20, 4'd0, 4'd2, 8'h10, 4'd0, 4'd1};
        bus.m_arvalid = 2'b11;
        tick();
        chk("t1_first_gnt", rd_gnt, 2'b01);
        chk("t1_first_s_ar", bus.s_ar, 16'h1001);
        rd_txn(0, 4'd0, 0);
        chk("t1_gnt_cleared", rd_gnt, 2'b00);
        tick();
        chk("t1_second_gnt", rd_gnt, 2'b10);
        chk("t1_second_s_ar", bus.s_ar, 16'h2002);
        rd_txn(1, 4'd0, 0);

        // 2: master1 LEN=3 with gappy slave data
        s0 = rd_beats[0];
        s1 = rd_beats[1];
        bus.m_ar[31:16] = {8'h40, 4'd3, 4'd4};
        bus.m_arvalid[1] = 1;
        rd_txn(1, 4'd3, 1);
        chk("t2_m1_beats", rd_beats[1] - s1, 4);
        chk("t2_m0_beats", rd_beats[0] - s0, 0);
        chk("t2_gnt_cleared", rd_gnt, 2'b00);

        // 3: master0 LEN=2 write, correct WLAST
        sw = wlast_cnt;
        sb = b_cnt;
        bus.m_aw[15:0] = {8'h30, 4'd2, 4'd3};
        bus.m_awvalid[0] = 1;
        wr_txn(0, 4'd2, 8'hA1, 2, 5'h00);
        chk("t3_wlast_beat", wlast_at, 3);
        chk("t3_wlast_pulses", wlast_cnt - sw, 1);
        chk("t3_wlast_err", wlast_err, 2'b00);
        chk("t3_bresp", last_bresp, 5'h00);
        chk("t3_b_handshakes", b_cnt - sb, 1);
        chk("t3_gnt_cleared", wr_gnt, 2'b00);

        // 4: master1 LEN=1 with early WLAST
        bus.m_aw[31:16] = {8'h50, 4'd1, 4'd5};
        bus.m_awvalid[1] = 1;
        wr_txn(1, 4'd1, 8'hB1, 0, 5'h02);
        chk("t4_wlast_beat", wlast_at, 2);
        chk("t4_wlast_err", wlast_err, 2'b10);
        chk("t4_bresp", last_bresp, 5'h02);
        tick(); tick(); tick();
        chk("t4_wlast_err_sticky", wlast_err, 2'b10);

        // 5: concurrent read (master0) and write (master1)
        both_seen = 0;
        s0 = rd_beats[0];
        s1 = rd_beats[1];
        bus.m_ar[15:0] = {8'h70, 4'd1, 4'd7};
        bus.m_arvalid[0] = 1;
        bus.m_aw[31:16] = {8'h80, 4'd0, 4'd8};
        bus.m_awvalid[1] = 1;
        fork
            rd_txn(0, 4'd1, 0);
            wr_txn(1, 4'd0, 8'hD1, 0, 5'h04);
        join
        chk("t5_both_granted", both_seen, 1'b1);
        chk("t5_m0_beats", rd_beats[0] - s0, 2);
        chk("t5_m1_beats", rd_beats[1] - s1, 0);
        chk("t5_idle", {rd_gnt, wr_gnt}, 4'b0000);

        // 6: reset in the middle of a write burst
        bus.m_aw[31:16] = {8'h60, 4'd2, 4'd6};
        bus.m_awvalid[1] = 1;
        wait_gnt(1, 1, ok);
        bus.s_awready = 1;
        tick();
        bus.s_awready = 0;
        bus.m_awvalid[1] = 0;
        bus.s_wready = 1;
        bus.m_wvalid[1] = 1;
        bus.m_wdata[15:8] = 8'h61;
        wr_exp_q.push_back(8'h61);
        tick();
        rst = 1;
        #1;
        chk("t6_rst_wr_gnt", wr_gnt, 2'b00);
        chk("t6_rst_s_wvalid", bus.s_wvalid, 1'b0);
        chk("t6_rst_m_wready", bus.m_wready, 2'b00);
        chk("t6_rst_wlast_err", wlast_err, 2'b00);
        drive_idle();
        tick();
        tick();
        rst = 0;
        bus.m_aw = {8'h91, 4'd0, 4'd9, 8'h90, 4'd0, 4'd9};
        bus.m_awvalid = 2'b11;
        bus.m_ar = {8'h93, 4'd0, 4'd3, 8'h92, 4'd0, 4'd2};
        bus.m_arvalid = 2'b11;
        tick();
        chk("t6_new_wr_gnt", wr_gnt, 2'b01);
        chk("t6_new_rd_gnt", rd_gnt, 2'b01);
        chk("t6_new_s_aw", bus.s_aw, 16'h9009);
        fork
            begin
                wr_txn(0, 4'd0, 8'hE1, 0, 5'h00);
                wr_txn(1, 4'd0, 8'hE2, 0, 5'h00);
            end
            begin
                rd_txn(0, 4'd0, 0);
                rd_txn(1, 4'd0, 0);
            end
        join
        tick();
        tick();
        chk("end_rd_q_empty", rd_exp_q.size(), 0);
        chk("end_wr_q_empty", wr_exp_q.size(), 0);
        chk("end_idle", {rd_gnt, wr_gnt}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_rw_arbiter.md
Name: axi_rw_arbiter

Overview:
- Two-master, one-slave arbiter for the 8-bit AXI-style read and write channels used by the team's master block.
- Read path (AR/R) and write path (AW/W/B) are arbitrated independently, each with its own round-robin pointer.
- A grant is held for the whole transaction: until the RLAST beat for reads, and until the B handshake for writes.
- The block also generates the slave-side WLAST from a beat counter and flags masters whose WLAST is inconsistent with AWLEN.

Parameters:
- ADDR_W, 8, address width per master.
- DATA_W, 8, data beat width.
- BRESP_W, 5, write-response width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m_arvalid  in  2  per-master read request, bit i = master i
- m_arready  out  2  per-master AR accept
- m_ar  in  32  per master {ADDR[15:8], LEN[7:4], ID[3:0]}; master i at [16i+:16]
- m_rvalid  out  2  per-master read beat valid
- m_rready  in  2  per-master read ready
- m_rdata  out  8  shared read data, valid only with the granted master's rvalid
- m_rresp  out  1  shared read response
- m_rlast  out  1  shared read last
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_ar  out  16  slave {ADDR, LEN, ID}
- s_rvalid  in  1  slave read valid
- s_rready  out  1  slave read ready
- s_rdata  in  8  slave read data
- s_rresp  in  1  slave read response
- s_rlast  in  1  slave read last
- m_awvalid  in  2  per-master write request
- m_awready  out  2  per-master AW accept
- m_aw  in  32  packed like m_ar
- m_wvalid  in  2  per-master write beat valid
- m_wready  out  2  per-master write ready
- m_wdata  in  16  master i at [8i+:8]
- m_wlast  in  2  per-master last flag
- m_bvalid  out  2  per-master write response valid
- m_bready  in  2  per-master write response ready
- m_bresp  out  5  shared write response
- s_awvalid  out  1  slave AW valid
- s_awready  in  1  slave AW ready
- s_aw  out  16  slave {ADDR, LEN, ID}
- s_wvalid  out  1  slave write valid
- s_wready  in  1  slave write ready
- s_wdata  out  8  slave write data
- s_wlast  out  1  slave write last, generated internally
- s_bvalid  in  1  slave write response valid
- s_bready  out  1  slave write response ready
- s_bresp  in  5  slave write response
- wlast_err  out  2  sticky per-master WLAST/length mismatch flag
- rd_gnt  out  2  one-hot read grant, 0 when idle
- wr_gnt  out  2  one-hot write grant, 0 when idle

Behaviour:
Reset and outputs:
- Reset rst, asynchronous, active-high; clock clk.
- On reset: both FSMs go to IDLE, all outputs are 0, beat counter is 0, wlast_err is 0.
- On reset, both last-granted pointers are set to 1, so master 0 wins the first contest.
- Reset asserted mid-transaction abandons the transaction silently; no slave cleanup is performed.
- Only state, grant, pointers, counter and wlast_err are registered. All channel outputs are combinational muxes selected by the registered grant and state.
- The non-granted master always sees ready/valid = 0.

Read FSM: RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE.
- RD_IDLE: if any m_arvalid bit is set, grant as follows:
  - Only one requester: grant that master.
  - Both requesting: grant the master other than the last-granted one.
  - Move to RD_ADDR. s_arvalid rises exactly 1 cycle after m_arvalid is sampled.
- RD_ADDR:
  - s_arvalid = 1 and s_ar = m_ar[g].
  - m_arready[g] = s_arready.
  - On s_arready, move to RD_DATA.
- RD_DATA:
  - m_rvalid[g] = s_rvalid and s_rready = m_rready[g].
  - rdata, rresp and rlast are passed straight through.
  - On s_rvalid & s_rready & s_rlast: update the pointer to g, clear rd_gnt, return to RD_IDLE.
  - A new grant can be made on the following cycle.
- A request arriving while busy waits; it is not dropped.

Write FSM: WR_IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> WR_IDLE.
- WR_IDLE / WR_ADDR: same grant rule as the read path, using its own pointer.
- On the AW handshake:
  - Latch len = s_aw[7:4].
  - Clear the 5-bit beat counter.
  - Move to WR_DATA.
- WR_DATA:
  - s_wvalid = m_wvalid[g], m_wready[g] = s_wready, s_wdata = m_wdata[g].
  - s_wlast = (cnt == len); a burst has len+1 beats, so len=0 means 1 beat and len=15 means 16 beats.
  - cnt increments on each s_wvalid & s_wready.
  - On the handshake with cnt == len, move to WR_RESP.
  - If m_wlast[g] differs from s_wlast on any accepted beat, set wlast_err[g]. It stays set until reset. The transfer still completes on the count.
- WR_RESP:
  - m_bvalid[g] = s_bvalid, s_bready = m_bready[g], m_bresp = s_bresp.
  - On the B handshake: update the pointer, clear wr_gnt, return to WR_IDLE.

Concurrency:
- Read and write paths are independent. One master may hold the read grant while the other holds the write grant, or one master may hold both.

Test Plan:
1. Reset, then m_arvalid=2'b11 with master0 ADDR 0x10/LEN 0 and master1 ADDR 0x20/LEN 0 -> rd_gnt=01 the next cycle; s_ar=0x1000 | ID. After master0's RLAST, rd_gnt=10 and s_ar carries ADDR 0x20.
2. Master1 reads LEN=3 while slave RVALID toggles every other cycle -> exactly 4 beats reach master1 with data unchanged; m_rvalid[0] stays 0; rd_gnt clears 1 cycle after the RLAST handshake.
3. Master0 writes LEN=2 with data 0xA1, 0xA2, 0xA3 and m_wlast on beat 3 -> s_wlast high only on the 3rd beat; wlast_err=00; m_bresp=5'h00 forwarded; wr_gnt clears.
4. Master1 writes LEN=1 but asserts m_wlast on beat 1 -> s_wlast on beat 2; wlast_err=10 and it persists after the transaction.
5. Concurrent traffic: master0 reads LEN=1 while master1 writes LEN=0 -> rd_gnt=01 and wr_gnt=10 simultaneously; both complete with no cross-routing of valids.
6. Assert rst in WR_DATA after beat 1 -> all outputs 0 and wr_gnt=00; a new request afterwards is granted to master0.
